// File: rtl/pbit_field_acc_pkg.sv
// pbit_field_acc_pkg
//   Shared definitions for the p-bit local-field datapath: default Q-format
//   widths, the sequencer state encoding and a helper for address widths.
//   No ports; imported by pbit_field_acc and its qmult stage.
package pbit_field_acc_pkg;

  localparam int Q_DEF = 15;
  localparam int N_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SAT  = 2'd2,
    S_MUL  = 2'd3
  } state_t;

  // Address width for n entries, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pbit_field_acc_qmult.sv
// pbit_field_acc_qmult
//   Combinational sign-magnitude fixed-point multiplier (Q fraction bits,
//   N-bit words including the sign). The product magnitude is truncated
//   after the Q-bit shift; o_ovr flags any magnitude bits lost above N-2.
// Ports
//   i_multiplicand  in  N  sign-magnitude operand
//   i_multiplier    in  N  sign-magnitude operand
//   o_result        out N  sign-magnitude product (sign may be set on a zero magnitude)
//   o_ovr           out 1  magnitude overflow
module pbit_field_acc_qmult
  import pbit_field_acc_pkg::*;
#(
  parameter int Q = Q_DEF,
  parameter int N = N_DEF
) (
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  output logic [N-1:0] o_result,
  output logic         o_ovr
);

  logic [2*N-3:0] prod;
  logic [2*N-3:0] prod_shr;

  assign prod     = {{(N-1){1'b0}}, i_multiplicand[N-2:0]} *
                    {{(N-1){1'b0}}, i_multiplier[N-2:0]};
  assign prod_shr = prod >> Q;

  assign o_result = {i_multiplicand[N-1] ^ i_multiplier[N-1], prod_shr[N-2:0]};
  assign o_ovr    = |prod_shr[2*N-3:N-1];

endmodule

// File: rtl/pbit_field_acc.sv
// pbit_field_acc
//   Local field of one p-bit: I = beta * (h + sum_j J_j*m_j), m_j in {-1,+1}.
//   Walks a synchronous weight RAM over NUM_NBR neighbours, accumulates
//   exactly in two's complement, saturates to the sign-magnitude range and
//   scales by beta through the qmult stage.
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_start          request a computation (sampled in IDLE only)
//   i_bias, i_beta   h and beta, sign-magnitude, latched on accepted start
//   i_spins          neighbour states (1 = +1, 0 = -1), latched on accepted start
//   o_w_en, o_w_addr weight RAM read port; i_w_data valid one cycle later
//   o_busy           computation in progress
//   o_done           one-cycle pulse, o_field/o_ovr valid and held until next pulse
//   o_field, o_ovr   scaled field (sign-magnitude) and saturation/overflow flag
//
// state | meaning
// IDLE  | waiting for i_start
// RUN   | issue weight reads, accumulate returned weights (NUM_NBR+1 cycles)
// SAT   | clamp accumulator and convert to sign-magnitude
// MUL   | register beta-scaled result, pulse o_done
module pbit_field_acc
  import pbit_field_acc_pkg::*;
#(
  parameter  int Q       = Q_DEF,
  parameter  int N       = N_DEF,
  parameter  int NUM_NBR = 8,
  localparam int IDX_W   = idx_width(NUM_NBR)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [N-1:0]       i_bias,
  input  logic [N-1:0]       i_beta,
  input  logic [NUM_NBR-1:0] i_spins,
  output logic               o_w_en,
  output logic [IDX_W-1:0]   o_w_addr,
  input  logic [N-1:0]       i_w_data,
  output logic               o_busy,
  output logic               o_done,
  output logic [N-1:0]       o_field,
  output logic               o_ovr
);

  localparam int CNT_W = $clog2(NUM_NBR + 1);
  // Wide enough that h plus NUM_NBR full-scale weights can never wrap.
  localparam int ACC_W = N + IDX_W + 1;

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t MAX_ABS = acc_t'({(N-1){1'b1}});

  function automatic acc_t sm2tc(input logic [N-1:0] x);
    acc_t mag;
    mag = acc_t'({{(ACC_W-N+1){1'b0}}, x[N-2:0]});
    return x[N-1] ? -mag : mag;
  endfunction

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  acc_t               acc;
  logic [N-1:0]       beta_q;
  logic [NUM_NBR-1:0] spins_sh;
  logic [N-1:0]       sum_sm;
  logic               sat_q;

  acc_t               w_tc;
  acc_t               acc_abs;
  logic               acc_neg;
  logic               acc_big;
  logic [N-2:0]       sat_mag;
  logic [N-1:0]       q_res;
  logic               q_ovr;

  always_comb begin
    w_tc    = sm2tc(i_w_data);
    acc_neg = acc[ACC_W-1];
    acc_abs = acc_neg ? -acc : acc;
    acc_big = (acc_abs > MAX_ABS);
    sat_mag = acc_big ? {(N-1){1'b1}} : acc_abs[N-2:0];
  end

  pbit_field_acc_qmult #(
    .Q (Q),
    .N (N)
  ) u_qmult (
    .i_multiplicand (sum_sm),
    .i_multiplier   (beta_q),
    .o_result       (q_res),
    .o_ovr          (q_ovr)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      beta_q   <= '0;
      spins_sh <= '0;
      sum_sm   <= '0;
      sat_q    <= 1'b0;
      o_w_en   <= 1'b0;
      o_w_addr <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_field  <= '0;
      o_ovr    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            beta_q   <= i_beta;
            spins_sh <= i_spins;
            acc      <= sm2tc(i_bias);
            cnt      <= '0;
            o_w_en   <= 1'b1;
            o_w_addr <= '0;
            o_busy   <= 1'b1;
            state    <= S_RUN;
          end
        end

        S_RUN: begin
          // Data returning this cycle belongs to address cnt-1; the spin
          // shift register stays aligned with it.
          if (cnt != '0) begin
            acc      <= acc + (spins_sh[0] ? w_tc : -w_tc);
            spins_sh <= spins_sh >> 1;
          end
          if (o_w_en) begin
            if (o_w_addr == IDX_W'(NUM_NBR - 1)) begin
              o_w_en   <= 1'b0;
              o_w_addr <= '0;
            end else begin
              o_w_addr <= o_w_addr + 1'b1;
            end
          end
          if (cnt == CNT_W'(NUM_NBR)) begin
            state <= S_SAT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_SAT: begin
          // A zero accumulator has a clear sign bit, so no -0 is produced here.
          sum_sm <= {acc_neg, sat_mag};
          sat_q  <= acc_big;
          state  <= S_MUL;
        end

        S_MUL: begin
          o_field <= {q_res[N-1] & (|q_res[N-2:0]), q_res[N-2:0]};
          o_ovr   <= sat_q | q_ovr;
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pbit_field_acc.sv
module tb_pbit_field_acc;

  localparam int N  = 32;
  localparam int NN = 4;
  localparam int LAT = NN + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  bias = '0;
  logic [N-1:0]  beta = '0;
  logic [NN-1:0] spins = '0;
  logic          w_en;
  logic [1:0]    w_addr;
  logic [N-1:0]  w_data = '0;
  logic          busy;
  logic          done;
  logic [N-1:0]  field;
  logic          ovr;

  pbit_field_acc #(
    .Q       (15),
    .N       (N),
    .NUM_NBR (NN)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_bias   (bias),
    .i_beta   (beta),
    .i_spins  (spins),
    .o_w_en   (w_en),
    .o_w_addr (w_addr),
    .i_w_data (w_data),
    .o_busy   (busy),
    .o_done   (done),
    .o_field  (field),
    .o_ovr    (ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous weight RAM; junk is driven whenever no read was issued.
  logic [N-1:0] wmem [NN];
  always @(posedge clk) w_data <= w_en ? wmem[w_addr] : 32'h5A5A5A5A;

  typedef struct {
    logic [N-1:0] field;
    logic         ovr;
    int           stamp;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_checks = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_miss++;
        $display("FAIL unexpected_done actual=done field=%h required=no done", field);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_field"}, field, e.field);
        check({e.name, "_ovr"}, {31'b0, ovr}, {31'b0, e.ovr});
        check({e.name, "_latency"}, 32'(cyc - e.stamp), 32'(LAT));
      end
    end
  end

  task automatic set_w(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] c, input logic [N-1:0] d);
    wmem[0] = a; wmem[1] = b; wmem[2] = c; wmem[3] = d;
  endtask

  // Call just after a negedge: the start is accepted on the next posedge.
  task automatic start_vec(input string name, input logic [N-1:0] b, input logic [N-1:0] bt,
                           input logic [NN-1:0] sp, input logic [N-1:0] ef, input logic eo);
    exp_t e;
    bias  = b;
    beta  = bt;
    spins = sp;
    start = 1'b1;
    e.field = ef;
    e.ovr   = eo;
    e.stamp = cyc + 1;
    e.name  = name;
    exp_q.push_back(e);
    n_vec++;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) begin
      n_checks++;
      n_miss++;
      $display("FAIL %s_timeout actual=no done required=done", name);
    end
  endtask

  task automatic run_vec(input string name, input logic [N-1:0] b, input logic [N-1:0] bt,
                         input logic [NN-1:0] sp, input logic [N-1:0] ef, input logic eo);
    start_vec(name, b, bt, sp, ef, eo);
    wait_done(name);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    set_w(32'h0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy",  {31'b0, busy},  32'h0);
    check("rst_done",  {31'b0, done},  32'h0);
    check("rst_field", field,          32'h0);
    check("rst_ovr",   {31'b0, ovr},   32'h0);
    check("rst_w_en",  {31'b0, w_en},  32'h0);

    set_w(32'h00004000, 32'h00004000, 32'h00004000, 32'h00004000);
    run_vec("all_plus",  32'h0, 32'h00008000, 4'b1111, 32'h00010000, 1'b0);
    run_vec("cancel",    32'h0, 32'h00008000, 4'b1010, 32'h00000000, 1'b0);
    run_vec("neg_beta",  32'h0, 32'h80008000, 4'b1111, 32'h80010000, 1'b0);
    run_vec("mul_ovr",   32'h0, 32'h40000000, 4'b1111, 32'h00000000, 1'b1);

    set_w(32'h0, 32'h0, 32'h0, 32'h0);
    run_vec("neg_bias",  32'h80002000, 32'h00010000, 4'b1111, 32'h80004000, 1'b0);
    run_vec("max_nosat", 32'h7FFFFFFF, 32'h00008000, 4'b0000, 32'h7FFFFFFF, 1'b0);

    set_w(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    run_vec("sat_pos",   32'h0, 32'h00008000, 4'b1111, 32'h7FFFFFFF, 1'b1);
    run_vec("sat_neg",   32'h0, 32'h00008000, 4'b0000, 32'hFFFFFFFF, 1'b1);

    // -1.0 - 0.5 + 0.25 - (-0) + 0.125 = -1.125
    set_w(32'h00008000, 32'h80004000, 32'h00002000, 32'h80000000);
    run_vec("mixed",     32'h00001000, 32'h00008000, 4'b0110, 32'h80009000, 1'b0);

    // Start pulses mid-RUN with a different bias must not be taken.
    set_w(32'h00004000, 32'h00004000, 32'h00004000, 32'h00004000);
    start_vec("ignore", 32'h0, 32'h00008000, 4'b1111, 32'h00010000, 1'b0);
    repeat (2) @(negedge clk);
    check("busy_in_run", {31'b0, busy}, 32'h1);
    bias  = 32'h7FFFFFFF;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("ignore");
    check("busy_at_done", {31'b0, busy}, 32'h0);
    @(negedge clk);

    // Second start lands in the o_done cycle of the first.
    start_vec("b2b_a", 32'h0, 32'h00008000, 4'b1111, 32'h00010000, 1'b0);
    wait_done("b2b_a");
    start_vec("b2b_b", 32'h00008000, 32'h00008000, 4'b1111, 32'h00018000, 1'b0);
    wait_done("b2b_b");
    @(negedge clk);

    // Reset mid-RUN: abort without a done, field cleared.
    bias  = 32'h0;
    beta  = 32'h00008000;
    spins = 4'b1111;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_pre_rst", {31'b0, busy}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy",  {31'b0, busy}, 32'h0);
    check("abort_field", field,         32'h0);
    check("abort_w_en",  {31'b0, w_en}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_field_after", field, 32'h0);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL pending_results actual=%0d required=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
